// File: rtl/rs170_rx_in.sv
// RS170 parallel video receiver: samples the pads on the pixel clock and emits
// active pixels as an AXI4-Stream video stream with per-frame line/pixel statistics.
module rs170_rx_in #(
  parameter int AXIS_DATA_WIDTH = 16,
  parameter int FIFO_DEPTH      = 16,
  parameter int CNT_WIDTH       = 12
) (
  input  logic                       i_pclk,
  input  logic                       i_rstn,
  input  logic                       i_vsync,
  input  logic                       i_hsync,
  input  logic                       i_blank,
  input  logic                       i_field,
  input  logic [AXIS_DATA_WIDTH-1:0] i_data,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tuser,
  output logic                       m_axis_tlast,
  output logic                       o_field,
  output logic [CNT_WIDTH-1:0]       o_line_len,
  output logic [CNT_WIDTH-1:0]       o_frame_lines,
  output logic                       o_overflow,
  input  logic                       i_ovf_clr,
  output logic [1:0]                 dbg_state,
  output logic                       dbg_hsync
);

  // AXI4-Stream handshake: a beat transfers on a rising edge where tvalid and
  // tready are both 1; tdata/tuser/tlast hold steady while tvalid=1 and tready=0.

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = AXIS_DATA_WIDTH + 2;
  localparam logic [AW:0] DEPTH_LVL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    SYNC    = 2'd1,
    ACTIVE  = 2'd2,
    DROP    = 2'd3
  } state_t;

  state_t state;

  // ---------------------------------------------------------------------------
  // Input stage: two registers on every video input, plus one more vsync tap
  // for edge detection. Blank resets to 1 so reset release never looks active.
  // ---------------------------------------------------------------------------
  logic                       vs_s1, vs_s2, vs_s3;
  logic                       bl_s1, bl_s2;
  logic                       fd_s1, fd_s2;
  logic                       hs_s1, hs_s2;
  logic [AXIS_DATA_WIDTH-1:0] d_s1, d_s2;

  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      vs_s1 <= 1'b0;
      vs_s2 <= 1'b0;
      vs_s3 <= 1'b0;
      bl_s1 <= 1'b1;
      bl_s2 <= 1'b1;
      fd_s1 <= 1'b0;
      fd_s2 <= 1'b0;
      hs_s1 <= 1'b0;
      hs_s2 <= 1'b0;
      d_s1  <= '0;
      d_s2  <= '0;
    end else begin
      vs_s1 <= i_vsync;
      vs_s2 <= vs_s1;
      vs_s3 <= vs_s2;
      bl_s1 <= i_blank;
      bl_s2 <= bl_s1;
      fd_s1 <= i_field;
      fd_s2 <= fd_s1;
      hs_s1 <= i_hsync;
      hs_s2 <= hs_s1;
      d_s1  <= i_data;
      d_s2  <= d_s1;
    end
  end

  logic vs_rise;
  logic act;

  assign vs_rise   = vs_s2 & ~vs_s3;
  assign act       = ~bl_s2;
  assign dbg_hsync = hs_s2;
  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Hold register and FIFO write decision. The held pixel is written once the
  // following sample is visible, so tlast can be decided from that sample.
  // ---------------------------------------------------------------------------
  logic                       hold_valid;
  logic                       hold_sof;
  logic [AXIS_DATA_WIDTH-1:0] hold_data;

  logic [AW:0] mem_cnt;
  logic [AW:0] occ;
  logic        full;
  logic        wr_try;
  logic        wr_en;
  logic        wr_last;
  logic        ovf_set;

  assign occ     = mem_cnt + {{AW{1'b0}}, m_axis_tvalid};
  assign full    = (occ == DEPTH_LVL);
  assign wr_try  = hold_valid & (state == ACTIVE);
  assign wr_en   = wr_try & ~full;
  assign ovf_set = wr_try & full;
  assign wr_last = ~act | vs_rise;

  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      state      <= WAIT_VS;
      hold_valid <= 1'b0;
      hold_sof   <= 1'b0;
      hold_data  <= '0;
    end else if (vs_rise) begin
      // A new frame always wins; an active sample on the same edge is its first pixel.
      if (act) begin
        state      <= ACTIVE;
        hold_valid <= 1'b1;
        hold_sof   <= 1'b1;
        hold_data  <= d_s2;
      end else begin
        state      <= SYNC;
        hold_valid <= 1'b0;
      end
    end else begin
      case (state)
        WAIT_VS: hold_valid <= 1'b0;
        SYNC: begin
          if (act) begin
            state      <= ACTIVE;
            hold_valid <= 1'b1;
            hold_sof   <= 1'b1;
            hold_data  <= d_s2;
          end else begin
            hold_valid <= 1'b0;
          end
        end
        ACTIVE: begin
          if (wr_try && full) begin
            state      <= DROP;
            hold_valid <= 1'b0;
          end else if (act) begin
            hold_valid <= 1'b1;
            hold_sof   <= 1'b0;
            hold_data  <= d_s2;
          end else begin
            hold_valid <= 1'b0;
          end
        end
        DROP: hold_valid <= 1'b0;
        default: begin
          state      <= WAIT_VS;
          hold_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_overflow <= 1'b0;
    end else if (ovf_set) begin
      o_overflow <= 1'b1;
    end else if (i_ovf_clr) begin
      o_overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO: storage array followed by an output register. Occupancy counts both,
  // so FIFO_DEPTH beats in total can be held under backpressure.
  // ---------------------------------------------------------------------------
  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          load_out;

  assign load_out = (mem_cnt != '0) & (~m_axis_tvalid | m_axis_tready);

  always_ff @(posedge i_pclk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {hold_sof, wr_last, hold_data};
    end
  end

  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      mem_cnt       <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load_out) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      mem_cnt <= mem_cnt + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, load_out};
      if (load_out) begin
        m_axis_tvalid <= 1'b1;
        {m_axis_tuser, m_axis_tlast, m_axis_tdata} <= mem[rd_ptr];
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics run in every state so dropped or oversized frames are measured.
  // ---------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] pix_cnt;
  logic [CNT_WIDTH-1:0] line_cnt;
  logic [CNT_WIDTH-1:0] line_next;
  logic                 eol;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign eol       = (pix_cnt != '0) & (~act | vs_rise);
  assign line_next = eol ? sat_inc(line_cnt) : line_cnt;

  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      pix_cnt       <= '0;
      line_cnt      <= '0;
      o_line_len    <= '0;
      o_frame_lines <= '0;
      o_field       <= 1'b0;
    end else begin
      if (eol) begin
        o_line_len <= pix_cnt;
        pix_cnt    <= act ? CNT_WIDTH'(1) : '0;
      end else if (act) begin
        pix_cnt <= sat_inc(pix_cnt);
      end
      // The line cut short by vsync is counted into the frame being closed.
      if (vs_rise) begin
        o_frame_lines <= line_next;
        line_cnt      <= '0;
        o_field       <= fd_s2;
      end else begin
        line_cnt <= line_next;
      end
    end
  end

endmodule

// File: tb/tb_rs170_rx_in.sv
// Bench for rs170_rx_in: directed RS170 frames in, AXI4-Stream beats checked
// against an expected queue filled as each pixel is driven.
module tb_rs170_rx_in;

  localparam int W = 16;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vsync, hsync, blank, field;
  logic [W-1:0]  data;
  logic [W-1:0]  tdata;
  logic          tvalid, tready, tuser, tlast;
  logic          o_field;
  logic [CW-1:0] line_len, frame_lines;
  logic          overflow, ovf_clr;
  logic [1:0]    dbg_state;
  logic          dbg_hsync;

  int checks = 0;
  int failures = 0;
  logic [W+1:0] exp_q[$];

  rs170_rx_in #(.AXIS_DATA_WIDTH(W), .FIFO_DEPTH(16), .CNT_WIDTH(CW)) dut (
    .i_pclk(clk), .i_rstn(rst_n), .i_vsync(vsync), .i_hsync(hsync),
    .i_blank(blank), .i_field(field), .i_data(data),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tuser(tuser), .m_axis_tlast(tlast), .o_field(o_field),
    .o_line_len(line_len), .o_frame_lines(frame_lines), .o_overflow(overflow),
    .i_ovf_clr(ovf_clr), .dbg_state(dbg_state), .dbg_hsync(dbg_hsync)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard monitor ----------------
  logic         stall_prev = 1'b0;
  logic [W+1:0] held;
  logic [W+1:0] mon_exp, mon_got;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      mon_got = {tuser, tlast, tdata};
      if (stall_prev) begin
        checks++;
        if (!tvalid || mon_got !== held) begin
          failures++;
          $display("FAIL hold_stable: got valid=%0b beat=%h required valid=1 beat=%h", tvalid, mon_got, held);
        end
      end
      if (tvalid && tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat: got user=%0b last=%0b data=%h, required no beat",
                   tuser, tlast, tdata);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            failures++;
            $display("FAIL beat: got user=%0b last=%0b data=%h required user=%0b last=%0b data=%h",
                     mon_got[W+1], mon_got[W], mon_got[W-1:0], mon_exp[W+1], mon_exp[W], mon_exp[W-1:0]);
          end
        end
      end
      stall_prev = tvalid && !tready;
      held = mon_got;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input int act_v, input int exp_v);
    checks++;
    if (act_v != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act_v, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_pad(input logic vs, input logic bl, input logic [W-1:0] d);
    vsync = vs;
    blank = bl;
    data  = d;
    step(1);
  endtask

  task automatic drive_vsync(input logic f);
    field = f;
    repeat (3) set_pad(1'b1, 1'b1, '0);
    repeat (3) set_pad(1'b0, 1'b1, '0);
  endtask

  task automatic drive_lines(input int first, input int n, input int npx, input bit push, input bit sof);
    logic [W-1:0] d;
    for (int l = 0; l < n; l++) begin
      for (int p = 0; p < npx; p++) begin
        d = 16'((first + l) * 16 + p);
        set_pad(1'b0, 1'b0, d);
        if (push) exp_q.push_back({(sof && l == 0 && p == 0), (p == npx - 1), d});
      end
      repeat (4) set_pad(1'b0, 1'b1, '0);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || tvalid) && n < budget) begin
      step(1);
      n++;
    end
    check("drain_remaining", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vsync = 0; hsync = 0; blank = 1; field = 0; data = '0;
    tready = 1; ovf_clr = 0; rst_n = 0;
    step(4);
    check("rst_tvalid", tvalid, 0);
    check("rst_tuser", tuser, 0);
    check("rst_tlast", tlast, 0);
    check("rst_field", o_field, 0);
    check("rst_line_len", line_len, 0);
    check("rst_frame_lines", frame_lines, 0);
    check("rst_overflow", overflow, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1;
    step(3);

    // 1: three 4x8 frames streaming freely
    for (int f = 0; f < 3; f++) begin
      drive_vsync(f[0]);
      drive_lines(0, 4, 8, 1, 1);
    end
    wait_drain(200);
    drive_vsync(1'b1);
    check("t1_frame_lines", frame_lines, 4);
    check("t1_line_len", line_len, 8);
    check("t1_field", o_field, 1);

    // 2: reset asserted mid-frame with beats buffered, released mid-frame
    tready = 0;
    drive_vsync(1'b0);
    drive_lines(0, 1, 8, 0, 0);
    for (int p = 0; p < 3; p++) set_pad(1'b0, 1'b0, 16'(16 + p));
    rst_n = 0;
    #1;
    check("t2_rst_tvalid", tvalid, 0);
    check("t2_rst_line_len", line_len, 0);
    check("t2_rst_frame_lines", frame_lines, 0);
    tready = 1;
    for (int p = 3; p < 5; p++) set_pad(1'b0, 1'b0, 16'(16 + p));
    rst_n = 1;
    for (int p = 5; p < 8; p++) set_pad(1'b0, 1'b0, 16'(16 + p));
    repeat (4) set_pad(1'b0, 1'b1, '0);
    drive_lines(2, 2, 8, 0, 0);
    step(4);
    check("t2_no_beat", tvalid, 0);
    check("t2_wait_state", dbg_state, 0);
    drive_vsync(1'b1);
    drive_lines(0, 4, 8, 1, 1);
    wait_drain(200);
    check("t2_field", o_field, 1);

    // 3: one line under backpressure fits in the FIFO
    drive_vsync(1'b0);
    tready = 0;
    drive_lines(0, 1, 8, 1, 1);
    step(4);
    check("t3_tvalid_held", tvalid, 1);
    check("t3_overflow", overflow, 0);
    tready = 1;
    drive_lines(1, 3, 8, 1, 0);
    wait_drain(200);
    check("t3_overflow_after", overflow, 0);

    // 4: backpressure for a whole frame: first 16 beats kept, rest dropped
    drive_vsync(1'b1);
    tready = 0;
    drive_lines(0, 2, 8, 1, 1);
    drive_lines(2, 2, 8, 0, 0);
    check("t4_overflow", overflow, 1);
    check("t4_drop_state", dbg_state, 3);
    tready = 1;
    wait_drain(200);
    drive_vsync(1'b0);
    check("t4_frame_lines", frame_lines, 4);
    drive_lines(0, 4, 8, 1, 1);
    wait_drain(200);
    check("t4_overflow_sticky", overflow, 1);
    ovf_clr = 1;
    step(1);
    ovf_clr = 0;
    step(1);
    check("t4_overflow_clr", overflow, 0);

    // 5: vsync rises on px 6 of line 2, so px 5 closes the line and frame
    drive_vsync(1'b0);
    drive_lines(0, 2, 8, 1, 1);
    for (int p = 0; p < 6; p++) begin
      set_pad(1'b0, 1'b0, 16'(32 + p));
      exp_q.push_back({1'b0, (p == 5), 16'(32 + p)});
    end
    set_pad(1'b1, 1'b0, 16'h0026);
    exp_q.push_back({1'b1, 1'b0, 16'h0026});
    set_pad(1'b1, 1'b0, 16'h0027);
    exp_q.push_back({1'b0, 1'b1, 16'h0027});
    repeat (2) set_pad(1'b1, 1'b1, '0);
    repeat (4) set_pad(1'b0, 1'b1, '0);
    check("t5_frame_lines", frame_lines, 3);
    check("t5_line_len", line_len, 2);
    drive_lines(1, 2, 8, 1, 0);
    wait_drain(200);

    // 6: oversized line saturates the pixel counter
    drive_vsync(1'b0);
    check("t6_prev_frame_lines", frame_lines, 3);
    drive_lines(0, 1, 5000, 1, 1);
    check("t6_line_len_sat", line_len, 4095);
    wait_drain(200);
    drive_vsync(1'b0);
    check("t6_frame_lines", frame_lines, 1);
    check("t6_overflow", overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
